// File: rtl/apb_uart_tx_pkg.sv
// rtl/apb_uart_tx_pkg.sv - register map, LSR bit positions and TX FSM states for apb_uart_tx_lite
package apb_uart_tx_pkg;

    localparam logic [2:0] REG_THR_DLL = 3'd0;
    localparam logic [2:0] REG_IER_DLM = 3'd1;
    localparam logic [2:0] REG_LCR     = 3'd3;
    localparam logic [2:0] REG_LSR     = 3'd5;

    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;
    localparam int LCR_DLAB = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO, extra pointer MSB distinguishes full from empty
module uart_tx_fifo #(
    parameter int Depth = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(Depth);

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]  mem_q [Depth];
    logic        push_ok, pop_ok;

    // A push into a full FIFO is legal when the head is leaving in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/apb_uart_tx_lite.sv
// rtl/apb_uart_tx_lite.sv - APB3 transmit-only 16550-subset UART, 8N1; APB_UART_TX_SIM_PRINT_EN echoes THR bytes to the console
module apb_uart_tx_lite #(
    parameter int          FifoDepth  = 8,
    parameter logic [15:0] DefaultDiv = 16'd434
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        tx_o,
    output logic        irq_o
);
    import apb_uart_tx_pkg::*;

    logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, lcr_q, lcr_d;
    logic [1:0]  ier_q, ier_d;
    logic        irq_q, irq_d, tx_q, tx_d;
    tx_state_e   state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  data_cnt_q, data_cnt_d;
    logic [7:0]  shreg_q, shreg_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        access, commit, thr_sel;
    logic [2:0]  reg_off;
    logic [15:0] div, reload;
    logic [7:0]  rdata;
    logic        unused_bits;

    assign unused_bits = ^{paddr_i[31:5], paddr_i[1:0], pwdata_i[31:8]};

    assign reg_off   = paddr_i[4:2];
    assign access    = psel_i & penable_i;
    assign thr_sel   = (reg_off == REG_THR_DLL) & ~lcr_q[LCR_DLAB];
    assign pready_o  = ~(rst_ni & access & pwrite_i & thr_sel & fifo_full & ~fifo_pop);
    assign commit    = rst_ni & access & pwrite_i & pready_o;
    assign fifo_push = commit & thr_sel;
    assign pslverr_o = 1'b0;
    assign div       = {dlm_q, dll_q};
    assign reload    = (div == 16'd0) ? 16'd0 : div - 16'd1;

    uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (pwdata_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        dll_d = dll_q;
        dlm_d = dlm_q;
        ier_d = ier_q;
        lcr_d = lcr_q;
        if (commit) begin
            case (reg_off)
                REG_THR_DLL: if (lcr_q[LCR_DLAB]) dll_d = pwdata_i[7:0];
                REG_IER_DLM: if (lcr_q[LCR_DLAB]) dlm_d = pwdata_i[7:0];
                             else                 ier_d = pwdata_i[1:0];
                REG_LCR:     lcr_d = pwdata_i[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 8'd0;
        case (reg_off)
            REG_THR_DLL: if (lcr_q[LCR_DLAB]) rdata = dll_q;
            REG_IER_DLM: rdata = lcr_q[LCR_DLAB] ? dlm_q : {6'd0, ier_q};
            REG_LCR:     rdata = lcr_q;
            REG_LSR: begin
                rdata[LSR_THRE] = fifo_empty;
                rdata[LSR_TEMT] = fifo_empty & (state_q == IDLE);
            end
            default: ;
        endcase
    end

    assign prdata_o = (rst_ni & access & ~pwrite_i) ? {24'd0, rdata} : 32'd0;

    // Every state lasts reload+1 cycles; a divisor change is seen at the next reload.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_d   = START;
                    bit_cnt_d = reload;
                    shreg_d   = fifo_rdata;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_cnt_q == 16'd0) begin
                    state_d    = DATA;
                    bit_cnt_d  = reload;
                    data_cnt_d = 3'd0;
                    tx_d       = shreg_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt_q == 16'd0) begin
                    bit_cnt_d = reload;
                    if (data_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        data_cnt_d = data_cnt_q + 3'd1;
                        shreg_d    = {1'b0, shreg_q[7:1]};
                        tx_d       = shreg_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_d   = START;
                        bit_cnt_d = reload;
                        shreg_d   = fifo_rdata;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_d = ier_q[1] & fifo_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dll_q      <= DefaultDiv[7:0];
            dlm_q      <= DefaultDiv[15:8];
            ier_q      <= 2'd0;
            lcr_q      <= 8'd0;
            irq_q      <= 1'b0;
            tx_q       <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 16'd0;
            data_cnt_q <= 3'd0;
            shreg_q    <= 8'd0;
        end else begin
            dll_q      <= dll_d;
            dlm_q      <= dlm_d;
            ier_q      <= ier_d;
            lcr_q      <= lcr_d;
            irq_q      <= irq_d;
            tx_q       <= tx_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    assign tx_o  = tx_q;
    assign irq_o = irq_q;

`ifdef APB_UART_TX_SIM_PRINT_EN
    always @(posedge clk_i) begin
        if (fifo_push) begin
            $write("%c", pwdata_i[7:0]);
        end
    end
`endif

endmodule

// File: tb/tb_apb_uart_tx_lite.sv
// tb/tb_apb_uart_tx_lite.sv - self-checking bench: frame-level model compared every cycle plus literal pins
module tb_apb_uart_tx_lite;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'd0, pwdata = 32'd0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o, tx_o, irq_o;

    always #5 clk = ~clk;

    apb_uart_tx_lite #(.FifoDepth(DEPTH), .DefaultDiv(16'd434)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
        .pslverr_o(pslverr_o), .tx_o(tx_o), .irq_o(irq_o)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: FIFO as a queue, the transmitter as "frame + cycles since frame start".
    logic [7:0] m_q[$];
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_frame = 10'h3ff;
    logic [7:0] m_dll = 8'hB2, m_dlm = 8'h01, m_lcr = 8'h00;
    logic [1:0] m_ier = 2'd0;
    logic       m_irq = 1'b0;
    logic       m_nirq, m_wcommit;
    logic [7:0] m_tmp;

    function automatic int m_div();
        int d;
        d = {m_dlm, m_dll};
        return (d == 0) ? 1 : d;
    endfunction

    function automatic bit m_pop_now();
        return (m_q.size() > 0) && (!m_busy || m_cnt == 10 * m_div() - 1);
    endfunction

    function automatic logic m_pready();
        if (!rst_ni) return 1'b1;
        if (psel && penable && pwrite && paddr[4:2] == 3'd0 && !m_lcr[7]
            && m_q.size() == DEPTH && !m_pop_now()) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        logic thre, temt;
        thre = (m_q.size() == 0);
        temt = thre && !m_busy;
        case (off)
            3'd0: return m_lcr[7] ? {24'd0, m_dll} : 32'd0;
            3'd1: return m_lcr[7] ? {24'd0, m_dlm} : {30'd0, m_ier};
            3'd3: return {24'd0, m_lcr};
            3'd5: return {25'd0, temt, thre, 5'd0};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_ni) begin
            m_q.delete();
            m_busy = 1'b0; m_cnt = 0;
            m_dll = 8'hB2; m_dlm = 8'h01; m_lcr = 8'h00; m_ier = 2'd0; m_irq = 1'b0;
        end else begin
            m_nirq    = m_ier[1] && (m_q.size() == 0);
            m_wcommit = psel && penable && pwrite && m_pready();
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 10 * m_div()) m_busy = 1'b0;
            end
            if (!m_busy && m_q.size() > 0) begin
                m_tmp   = m_q.pop_front();
                m_frame = {1'b1, m_tmp, 1'b0};
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
            if (m_wcommit) begin
                case (paddr[4:2])
                    3'd0: if (m_lcr[7]) m_dll = pwdata[7:0]; else m_q.push_back(pwdata[7:0]);
                    3'd1: if (m_lcr[7]) m_dlm = pwdata[7:0]; else m_ier = pwdata[1:0];
                    3'd3: m_lcr = pwdata[7:0];
                    default: ;
                endcase
            end
            m_irq = m_nirq;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_o", {31'd0, tx_o}, {31'd0, m_busy ? m_frame[m_cnt / m_div()] : 1'b1});
            check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
            check("pready_o", {31'd0, pready_o}, {31'd0, m_pready()});
            check("pslverr_o", {31'd0, pslverr_o}, 32'd0);
            check("prdata_o", prdata_o,
                  (rst_ni && psel && penable && !pwrite) ? m_read(paddr[4:2]) : 32'd0);
        end
    end

    // Independent serial receiver, mid-bit sampling at the bench's known divisor.
    int         rx_div = 4;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_start_cyc = 0;
    logic [7:0] rx_byte = 8'd0;
    logic [7:0] rx_q[$];
    int         rx_starts[$];

    always @(negedge clk) begin
        if (!rst_ni) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (chk_en && tx_o === 1'b0) begin
                rx_busy = 1'b1; rx_cnt = 0; rx_start_cyc = cyc;
                rx_starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            for (int k = 1; k <= 8; k++)
                if (rx_cnt == k * rx_div + rx_div / 2) rx_byte[k-1] = tx_o;
            if (rx_cnt == 9 * rx_div + rx_div / 2) begin
                check("rx_stop_bit", {31'd0, tx_o}, 32'd1);
                rx_q.push_back(rx_byte);
                rx_busy = 1'b0;
            end
        end
    end

    int          stall_cnt = 0;
    int          t_acc = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_slverr = 1'b0;

    // Called at posedge+1; returns at posedge+1 after the committing edge.
    task automatic apb_xfer(input logic wr, input logic [2:0] off, input logic [7:0] d);
        int n;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = {27'd0, off, 2'b00}; pwdata = {24'h5A5A5A, d};
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        n = 0;
        while (pready_o !== 1'b1 && n < 500) begin
            n++; stall_cnt++;
            @(negedge clk);
        end
        if (n >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL apb_timeout: pready_o stuck at %b, required 1", pready_o);
        end
        t_acc = cyc; last_rdata = prdata_o; last_slverr = pslverr_o;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || m_q.size() > 0) && n < 20000) begin
            @(posedge clk); n++;
        end
        if (n >= 20000) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: transmitter still busy, required idle");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_div(input logic [7:0] lo, input logic [7:0] hi);
        apb_xfer(1, 3'd3, 8'h80);
        apb_xfer(1, 3'd0, lo);
        apb_xfer(1, 3'd1, hi);
        apb_xfer(1, 3'd3, 8'h00);
    endtask

    initial begin
        int n;
        // 1: reset values
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        check("reset_tx", {31'd0, tx_o}, 32'd1);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        apb_xfer(0, 3'd5, 8'h00);
        check("reset_lsr", last_rdata, 32'h60);
        apb_xfer(1, 3'd3, 8'h80);
        apb_xfer(0, 3'd0, 8'h00);
        check("reset_dll", last_rdata, 32'hB2);
        apb_xfer(0, 3'd1, 8'h00);
        check("reset_dlm", last_rdata, 32'h01);
        apb_xfer(1, 3'd3, 8'h00);

        // 2: single frame, div 4
        set_div(8'd4, 8'd0);
        rx_div = 4; rx_q.delete(); rx_starts.delete();
        apb_xfer(1, 3'd0, 8'h41);
        n = t_acc;
        wait_idle();
        check("t2_frames", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("t2_byte", {24'd0, rx_q[0]}, 32'h41);
        check("t2_latency", rx_start_cyc - n, 32'd2);
        apb_xfer(0, 3'd5, 8'h00);
        check("t2_lsr", last_rdata, 32'h60);

        // 3: div 2, ten back-to-back writes overrun the 8-entry FIFO
        set_div(8'd2, 8'd0);
        rx_div = 2; rx_q.delete(); rx_starts.delete(); stall_cnt = 0;
        for (int i = 0; i < 10; i++) apb_xfer(1, 3'd0, 8'h30 + 8'(i));
        check("t3_stalled", {31'd0, stall_cnt > 0}, 32'd1);
        wait_idle();
        check("t3_frames", rx_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check("t3_byte", {24'd0, rx_q[i]}, 32'h30 + i);
        for (int i = 1; i < rx_starts.size(); i++)
            check("t3_gap", rx_starts[i] - rx_starts[i-1], 32'd20);

        // 4: THR-empty interrupt
        rx_q.delete();
        apb_xfer(1, 3'd1, 8'h02);
        repeat (2) @(negedge clk);
        check("t4_irq_empty", {31'd0, irq_o}, 32'd1);
        @(posedge clk); #1;
        apb_xfer(1, 3'd0, 8'hC3);
        apb_xfer(1, 3'd0, 8'h3C);
        repeat (3) @(negedge clk);
        check("t4_irq_busy", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        wait_idle();
        check("t4_irq_drained", {31'd0, irq_o}, 32'd1);
        check("t4_frames", rx_q.size(), 32'd2);
        apb_xfer(1, 3'd1, 8'h00);

        // 5: reset during DATA bit 3
        rx_q.delete();
        apb_xfer(1, 3'd0, 8'hA5);
        n = 0;
        while (!rx_busy && n < 100) begin @(negedge clk); n++; end
        check("t5_started", {31'd0, rx_busy}, 32'd1);
        repeat (8) @(posedge clk);
        #1 rst_ni = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b1;
        @(negedge clk);
        check("t5_tx_idle", {31'd0, tx_o}, 32'd1);
        @(posedge clk); #1;
        apb_xfer(0, 3'd5, 8'h00);
        check("t5_lsr", last_rdata, 32'h60);
        check("t5_no_frame", rx_q.size(), 32'd0);

        // 6: divisor 0 behaves as 1; unmapped offset
        set_div(8'd0, 8'd0);
        rx_div = 1; rx_q.delete();
        apb_xfer(1, 3'd0, 8'hFF);
        wait_idle();
        check("t6_frames", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("t6_byte", {24'd0, rx_q[0]}, 32'hFF);
        apb_xfer(1, 3'd7, 8'h99);
        apb_xfer(0, 3'd7, 8'h00);
        check("t6_off7", last_rdata, 32'd0);
        check("t6_slverr", {31'd0, last_slverr}, 32'd0);
        apb_xfer(0, 3'd3, 8'h00);
        check("t6_lcr", last_rdata, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
